// File: rtl/wdog_rst_gen.sv
// wdog_rst_gen
//
// Watchdog and software reset generator. Watches a periodic kick and, on
// expiry or on an explicit software request, drives a fixed-length active-low
// pulse onto the board-level reset net. That net loops back through the
// board reset synchronizer, so the pulse normally ends with rst_n asserting
// and this block returning to IDLE.
//
// Parameters
//   TIMEOUT    ARMED cycles without a kick before expiry (>= 2)
//   PULSE_LEN  cycles RST_out_n is held low (>= 1)
//   HOLDOFF    cycles after a pulse during which all requests are ignored (>= 1)
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   en          in   watchdog enable (level)
//   kick        in   watchdog service, sampled every cycle
//   sw_rst_req  in   software reset request, sampled every cycle
//   RST_out_n   out  registered active-low reset request to the board net
//   timeout     out  registered one-cycle pulse marking watchdog expiry
//   busy        out  registered, high while in PULSE or HOLD

module wdog_rst_gen #(
    parameter int TIMEOUT   = 1024,
    parameter int PULSE_LEN = 16,
    parameter int HOLDOFF   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic kick,
    input  logic sw_rst_req,
    output logic RST_out_n,
    output logic timeout,
    output logic busy
);

    localparam int MAX_TP  = (TIMEOUT > PULSE_LEN) ? TIMEOUT : PULSE_LEN;
    localparam int MAX_ALL = (MAX_TP > HOLDOFF) ? MAX_TP : HOLDOFF;
    // One spare bit so the counter can never wrap before its terminal count.
    localparam int CW      = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            timeout_next;

    // Outputs are registered from the next-state decode so they change on the
    // same edge as the transition that defines them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            RST_out_n <= 1'b1;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            RST_out_n <= (state_next != PULSE);
            timeout   <= timeout_next;
            busy      <= (state_next == PULSE) || (state_next == HOLD);
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        timeout_next = 1'b0;

        case (state)
            IDLE: begin
                // Software request wins over enable; kicks mean nothing here.
                if (sw_rst_req) begin
                    state_next = PULSE;
                    cnt_next   = '0;
                end else if (en) begin
                    state_next = ARMED;
                    cnt_next   = '0;
                end
            end

            ARMED: begin
                // A kick in the expiry cycle still wins, so a late but valid
                // service never produces a reset.
                if (sw_rst_req) begin
                    state_next = PULSE;
                    cnt_next   = '0;
                end else if (!en) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (kick) begin
                    cnt_next = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next   = PULSE;
                    cnt_next     = '0;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end

            PULSE: begin
                // Inputs are ignored: once started, the pulse always completes.
                if (cnt == PULSE_LAST) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end

            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_next = en ? ARMED : IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_wdog_rst_gen.sv
// tb_wdog_rst_gen
//
// Directed bench for wdog_rst_gen with TIMEOUT=8, PULSE_LEN=4, HOLDOFF=3.
// Cycle numbering: after each rising edge the bench waits #1, checks the
// outputs belonging to that cycle, then drives the inputs that the next edge
// samples. Cycle 0 of a watchdog scenario is the first cycle spent in ARMED.

module tb_wdog_rst_gen;

    logic clk;
    logic rst_n;
    logic en;
    logic kick;
    logic sw_rst_req;
    logic RST_out_n;
    logic timeout;
    logic busy;

    int tests_run;
    int tests_failed;

    wdog_rst_gen #(
        .TIMEOUT   (8),
        .PULSE_LEN (4),
        .HOLDOFF   (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .kick       (kick),
        .sw_rst_req (sw_rst_req),
        .RST_out_n  (RST_out_n),
        .timeout    (timeout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in a cycle whose state is IDLE with rst_n released.
    task automatic do_reset();
        rst_n      = 1'b0;
        en         = 1'b0;
        kick       = 1'b0;
        sw_rst_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            tests_run++;
            if (RST_out_n !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL reset_idle RST_out_n cycle %0d: got %b want 1", c, RST_out_n);
            end
            tests_run++;
            if (timeout !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_idle timeout cycle %0d: got %b want 0", c, timeout);
            end
            tests_run++;
            if (busy !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_idle busy cycle %0d: got %b want 0", c, busy);
            end
            tick();
        end
    endtask

    // No kicks: expiry pulse at 8, PULSE 8..11, HOLD 12..14, re-armed at 15,
    // second expiry at 23.
    task automatic test_expiry();
        logic exp_to, exp_rst, exp_busy;
        do_reset();
        en = 1'b1;
        tick();
        for (int c = 0; c <= 30; c++) begin
            exp_to   = (c == 8) || (c == 23);
            exp_rst  = !((c >= 8 && c <= 11) || (c >= 23 && c <= 26));
            exp_busy = (c >= 8 && c <= 14) || (c >= 23 && c <= 29);
            tests_run++;
            if (timeout !== exp_to) begin
                tests_failed++;
                $display("[TB] FAIL expiry timeout cycle %0d: got %b want %b", c, timeout, exp_to);
            end
            tests_run++;
            if (RST_out_n !== exp_rst) begin
                tests_failed++;
                $display("[TB] FAIL expiry RST_out_n cycle %0d: got %b want %b", c, RST_out_n, exp_rst);
            end
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("[TB] FAIL expiry busy cycle %0d: got %b want %b", c, busy, exp_busy);
            end
            tick();
        end
    endtask

    // Kick every 7 cycles up to cycle 99; last kick is sampled at the end of
    // cycle 97, so cnt=0 in 98 and expiry lands in cycle 106 (8 edges after
    // the edge that sampled the kick).
    task automatic test_kick();
        logic exp_to, exp_rst;
        do_reset();
        en = 1'b1;
        tick();
        for (int c = 0; c <= 108; c++) begin
            exp_to  = (c == 106);
            exp_rst = !(c >= 106);
            tests_run++;
            if (timeout !== exp_to) begin
                tests_failed++;
                $display("[TB] FAIL kick timeout cycle %0d: got %b want %b", c, timeout, exp_to);
            end
            tests_run++;
            if (RST_out_n !== exp_rst) begin
                tests_failed++;
                $display("[TB] FAIL kick RST_out_n cycle %0d: got %b want %b", c, RST_out_n, exp_rst);
            end
            kick = (c < 100) && (c % 7 == 6);
            tick();
        end
        kick = 1'b0;
    endtask

    // Kick in the cycle where cnt=7: no expiry, window restarts from cycle 8.
    task automatic test_kick_at_expiry();
        logic exp_to, exp_rst;
        do_reset();
        en = 1'b1;
        tick();
        for (int c = 0; c <= 17; c++) begin
            exp_to  = (c == 16);
            exp_rst = !(c >= 16);
            tests_run++;
            if (timeout !== exp_to) begin
                tests_failed++;
                $display("[TB] FAIL kick_at_expiry timeout cycle %0d: got %b want %b", c, timeout, exp_to);
            end
            tests_run++;
            if (RST_out_n !== exp_rst) begin
                tests_failed++;
                $display("[TB] FAIL kick_at_expiry RST_out_n cycle %0d: got %b want %b", c, RST_out_n, exp_rst);
            end
            kick = (c == 7);
            tick();
        end
        kick = 1'b0;
    endtask

    // Request in IDLE at cycle 0: pulse 1..4, busy 1..7. Repeat requests in
    // PULSE (cycle 2) and in the last HOLD cycle (7) must be ignored.
    task automatic test_sw_req();
        logic exp_rst, exp_busy;
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            exp_rst  = !(c >= 1 && c <= 4);
            exp_busy = (c >= 1 && c <= 7);
            tests_run++;
            if (RST_out_n !== exp_rst) begin
                tests_failed++;
                $display("[TB] FAIL sw_req RST_out_n cycle %0d: got %b want %b", c, RST_out_n, exp_rst);
            end
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("[TB] FAIL sw_req busy cycle %0d: got %b want %b", c, busy, exp_busy);
            end
            tests_run++;
            if (timeout !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL sw_req timeout cycle %0d: got %b want 0", c, timeout);
            end
            sw_rst_req = (c == 0) || (c == 2) || (c == 7);
            tick();
        end
        sw_rst_req = 1'b0;
    endtask

    // Request held high: pulses start every PULSE_LEN+HOLDOFF+1 = 8 cycles.
    task automatic test_back_to_back();
        logic exp_rst;
        do_reset();
        sw_rst_req = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            exp_rst = !((c >= 1 && c <= 4) || (c >= 9 && c <= 12) || (c >= 17 && c <= 20));
            tests_run++;
            if (RST_out_n !== exp_rst) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back RST_out_n cycle %0d: got %b want %b", c, RST_out_n, exp_rst);
            end
            tick();
        end
        sw_rst_req = 1'b0;
    endtask

    // rst_n low in the 2nd PULSE cycle (9): outputs clear in cycle 10, IDLE in
    // 10, ARMED from 11 with cnt cleared, so the next expiry shows in 19.
    task automatic test_rst_mid_pulse();
        logic exp_to, exp_rst, exp_busy;
        do_reset();
        en = 1'b1;
        tick();
        for (int c = 0; c <= 20; c++) begin
            exp_to   = (c == 8) || (c == 19);
            exp_rst  = !((c >= 8 && c <= 9) || (c >= 19));
            exp_busy = (c >= 8 && c <= 9) || (c >= 19);
            tests_run++;
            if (timeout !== exp_to) begin
                tests_failed++;
                $display("[TB] FAIL rst_mid_pulse timeout cycle %0d: got %b want %b", c, timeout, exp_to);
            end
            tests_run++;
            if (RST_out_n !== exp_rst) begin
                tests_failed++;
                $display("[TB] FAIL rst_mid_pulse RST_out_n cycle %0d: got %b want %b", c, RST_out_n, exp_rst);
            end
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("[TB] FAIL rst_mid_pulse busy cycle %0d: got %b want %b", c, busy, exp_busy);
            end
            rst_n = (c != 9);
            tick();
        end
        rst_n = 1'b1;
    endtask

    // en dropped during PULSE: pulse still 8..11, HOLD 12..14, then IDLE and
    // no further expiry.
    task automatic test_en_drop_mid_pulse();
        logic exp_to, exp_rst, exp_busy;
        do_reset();
        en = 1'b1;
        tick();
        for (int c = 0; c <= 30; c++) begin
            exp_to   = (c == 8);
            exp_rst  = !(c >= 8 && c <= 11);
            exp_busy = (c >= 8 && c <= 14);
            tests_run++;
            if (timeout !== exp_to) begin
                tests_failed++;
                $display("[TB] FAIL en_drop timeout cycle %0d: got %b want %b", c, timeout, exp_to);
            end
            tests_run++;
            if (RST_out_n !== exp_rst) begin
                tests_failed++;
                $display("[TB] FAIL en_drop RST_out_n cycle %0d: got %b want %b", c, RST_out_n, exp_rst);
            end
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("[TB] FAIL en_drop busy cycle %0d: got %b want %b", c, busy, exp_busy);
            end
            en = (c < 9);
            tick();
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        en           = 1'b0;
        kick         = 1'b0;
        sw_rst_req   = 1'b0;

        test_reset();
        test_expiry();
        test_kick();
        test_kick_at_expiry();
        test_sw_req();
        test_back_to_back();
        test_rst_mid_pulse();
        test_en_drop_mid_pulse();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
